// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and the fetch FIFO entry type
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
// Ports:
//   clk, rst (async, active-low)
//   flush            empties the FIFO; wins over push and pop
//   push, push_data  write one entry (caller guarantees no overflow)
//   pop              consume the head; ignored when empty
//   head             registered head entry
//   count            number of valid entries (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_en;

    assign pop_en = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction-fetch front end with redirect handling
// Ports:
//   clk, rst (async, active-low)
//   redirect_valid, redirect_pc         taken branch/jump pulse from EX
//   imem_req_valid/addr/ready           in-order word request channel
//   imem_rsp_valid/data                 in-order response channel, no back-pressure
//   out_valid/out_pc/out_instr/out_ready  buffered instruction stream to IF/ID
//   perf_delivered, perf_discarded      only when FETCH_PERF_EN is defined
// Optional: FETCH_PERF_EN adds delivered/discarded event counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_delivered,
    output logic [31:0]     perf_discarded
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            drop_rsp;
    logic            push;
    logic            pop;
    fetch_entry_t    head;

    // Outstanding requests plus buffered entries never exceed DEPTH, so every
    // response that is kept always has a FIFO slot waiting for it.
    assign credit_used    = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is stale if it belongs to a pre-redirect request, including
    // one that lands in the redirect cycle itself.
    assign drop_rsp = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
    assign push     = imem_rsp_valid && !drop_rsp;
    assign pop      = out_valid && out_ready && !redirect_valid;

    assign inflight_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                // Everything still outstanding after this cycle is stale.
                drop_cnt <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ('{pc: rsp_pc, instr: imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_delivered <= '0;
            perf_discarded <= '0;
        end else begin
            perf_delivered <= perf_delivered + 32'(pop);
            perf_discarded <= perf_discarded + 32'(drop_rsp)
                              + (redirect_valid ? 32'(count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_delivered;
    logic [31:0] perf_discarded;
`endif

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_delivered (perf_delivered),
        .perf_discarded (perf_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference: requests in flight (also the memory's pending list) and the
    // instructions expected to be waiting for decode.
    req_t        oq[$];
    ent_t        fq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_deliv;
    logic [31:0] m_disc;
    int          cyc;

    bit          redir;
    logic [31:0] redir_pc;
    bit          rdy_req;
    bit          rdy_out;
    int          lat;

    bit          obs_ov;
    bit          obs_rv;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;
    logic [31:0] obs_addr;
    int          obs_hs;

    int n_cmp;
    int n_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit   rsp_now;
        bit   exp_rv;
        req_t e;
        @(negedge clk);
        rsp_now = (oq.size() != 0) && (oq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? (oq[0].addr ^ 32'hFFFF_FFFF) : 32'h0;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        imem_req_ready = rdy_req;
        out_ready      = rdy_out;
        #1;
        exp_rv = !redir && ((oq.size() + fq.size()) < DEPTH);
        obs_ov    = out_valid;
        obs_rv    = imem_req_valid;
        obs_pc    = out_pc;
        obs_instr = out_instr;
        obs_addr  = imem_req_addr;
        if (imem_req_valid && imem_req_ready) obs_hs++;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
        check("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check("out_pc", out_pc, fq[0].pc);
            check("out_instr", out_instr, fq[0].instr);
        end
`ifdef FETCH_PERF_EN
        check("perf_delivered", perf_delivered, m_deliv);
        check("perf_discarded", perf_discarded, m_disc);
`endif
        @(posedge clk);
        if (rsp_now) e = oq.pop_front();
        if (!redir && rdy_out && fq.size() != 0) begin
            void'(fq.pop_front());
            m_deliv++;
        end
        if (rsp_now) begin
            if (redir || e.stale) m_disc++;
            else fq.push_back('{e.addr, e.addr ^ 32'hFFFF_FFFF});
        end
        if (redir) begin
            m_disc += 32'(fq.size());
            fq.delete();
            foreach (oq[i]) oq[i].stale = 1'b1;
            m_fetch_pc = redir_pc;
        end
        if (exp_rv && rdy_req) begin
            oq.push_back('{m_fetch_pc, cyc + lat, 1'b0});
            m_fetch_pc += 32'd4;
        end
        cyc++;
        redir = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redir          = 1'b0;
        redir_pc       = 32'h0;
        rdy_req        = 1'b0;
        rdy_out        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        out_ready      = 1'b0;
        oq.delete();
        fq.delete();
        m_fetch_pc = 32'h0;
        m_deliv    = 32'h0;
        m_disc     = 32'h0;
        obs_hs     = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int  first;
        bit  found;
        int  stale_seen;
        n_cmp = 0;
        n_mis = 0;
        cyc   = 0;
        lat   = 1;

        // Streaming with a 1-cycle memory
        do_reset();
        rdy_req = 1'b1;
        rdy_out = 1'b1;
        first   = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (first < 0 && obs_ov) first = i;
        end
        check("first_valid_cycle", 32'(first), 32'd2);

        // Decode stall fills exactly DEPTH credits, then resumes
        do_reset();
        rdy_req = 1'b1;
        rdy_out = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("stall_req_count", 32'(obs_hs), 32'd4);
        check("stall_req_valid", 32'(obs_rv), 32'd0);
        rdy_out = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // Memory not ready: request held at the reset PC
        do_reset();
        rdy_req = 1'b0;
        rdy_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_valid", 32'(obs_rv), 32'd1);
            check("hold_addr", obs_addr, 32'h0);
        end
        rdy_req = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Latency 3, redirect with three requests in flight
        do_reset();
        lat     = 3;
        rdy_req = 1'b1;
        rdy_out = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        redir    = 1'b1;
        redir_pc = 32'h100;
        cycle();
        found      = 1'b0;
        stale_seen = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (obs_ov && obs_pc < 32'h100) stale_seen++;
            if (!found && obs_ov) begin
                found = 1'b1;
                check("redir1_pc", obs_pc, 32'h100);
                check("redir1_instr", obs_instr, 32'hFFFF_FEFF);
            end
        end
        check("redir1_seen", 32'(found), 32'd1);
        check("redir1_stale", 32'(stale_seen), 32'd0);
        lat = 1;

        // Redirect coinciding with a response and a pop, FIFO holding two
        do_reset();
        rdy_req = 1'b1;
        rdy_out = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rdy_out  = 1'b1;
        redir    = 1'b1;
        redir_pc = 32'h200;
        cycle();
        cycle();
        check("redir2_empty", 32'(obs_ov), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && obs_ov) begin
                found = 1'b1;
                check("redir2_pc", obs_pc, 32'h200);
            end
            cycle();
        end
        check("redir2_seen", 32'(found), 32'd1);

        // Redirect to the top of the address space: PC wraps
        for (int i = 0; i < 5; i++) cycle();
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        cycle();
        cycle();
        check("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr1", obs_addr, 32'h0000_0000);
        for (int i = 0; i < 6; i++) cycle();

        // Randomized traffic, varying latency, with one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            rdy_req = ($urandom_range(0, 3) != 0);
            rdy_out = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redir    = 1'b1;
                redir_pc = $urandom;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end for the pipelined RV32 core. Sits after the program-counter stage and before the IF/ID pipeline register.
- Owns the fetch PC. Issues in-order word requests to instruction memory over a valid/ready request channel and an always-accepted response channel.
- Buffers returned instructions, tagged with their PCs, in a small FIFO toward decode.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- XLEN, 32, width of addresses, PCs and instruction words.
- DEPTH, 4, FIFO entries. Also the credit limit on outstanding requests plus buffered entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC value after reset.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- redirect_valid, input, 1, single-cycle pulse from EX: a taken branch or jump.
- redirect_pc, input, XLEN, target PC; valid while redirect_valid is high.
- imem_req_valid, output, 1, request valid.
- imem_req_addr, output, XLEN, request address; equals the fetch PC.
- imem_req_ready, input, 1, memory accepts the request.
- imem_rsp_valid, input, 1, response valid. Responses return in request order; there is no back-pressure.
- imem_rsp_data, input, XLEN, instruction word.
- out_valid, output, 1, FIFO head valid toward IF/ID.
- out_pc, output, XLEN, PC of the head instruction.
- out_instr, output, XLEN, head instruction.
- out_ready, input, 1, decode accepts the head; a stall holds it low.

Behaviour:
- Reset (async, rst=0):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - inflight=0, drop_cnt=0, FIFO count=0.
  - imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
  - Reset mid-operation abandons all outstanding requests. The memory model must reset on the same rst.
- Request issue:
  - imem_req_valid = !redirect_valid && (inflight + count < DEPTH). Combinational from registered state and redirect_valid.
  - imem_req_addr = fetch_pc.
  - On a handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^XLEN) and inflight += 1.
  - Address stays stable while valid is high and ready is low, unless a redirect occurs.
- Response:
  - Every imem_rsp_valid cycle decrements inflight. A handshake and a response in the same cycle leave inflight unchanged.
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed into the FIFO and rsp_pc += 4.
  - The credit rule guarantees a push never overflows, including a push while count == DEPTH-1 with a simultaneous pop.
- Output:
  - out_valid = (count != 0). out_pc and out_instr come from the registered FIFO head.
  - Pop when out_valid && out_ready.
  - Latency: a response in cycle N is presented on out_valid in cycle N+1. With a 1-cycle memory, request to out_valid is 2 cycles.
  - Simultaneous push and pop keeps count unchanged.
- Redirect (redirect_valid=1 in cycle N):
  - No request is issued in cycle N.
  - At the edge: fetch_pc ← redirect_pc, rsp_pc ← redirect_pc, FIFO count ← 0, and any pop in cycle N is ignored.
  - drop_cnt ← inflight after cycle N's accounting, i.e. inflight minus imem_rsp_valid. A response arriving in cycle N is itself discarded.
  - A redirect while drop_cnt > 0 replaces drop_cnt with the full new inflight value.
  - Back-to-back redirects: the last one wins.
- Invariants:
  - drop_cnt ≤ inflight ≤ DEPTH.
  - inflight + count ≤ DEPTH.
  - imem_req_addr[1:0] = redirect_pc[1:0] (no alignment checking).

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_delivered[31:0] (counts pops) and perf_discarded[31:0] (counts dropped responses plus FIFO entries flushed by redirects).
  - Both reset to 0 and wrap at 2^32.
- FETCH_PERF_EN not defined: the ports and counters are absent. Functional behaviour is identical either way.

Decomposition:
- Package fetch_pkg: XLEN, PC_STEP=4, RESET_PC default, and the fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, flush and count.
  - Registered head; flush takes priority over push and pop.
- The credit, drop and PC logic stay in fetch_unit.

Test Plan:
- Reset, then memory always ready with 1-cycle responses of data=addr^32'hFFFF_FFFF and out_ready=1 → out_pc sequence 0x0, 0x4, 0x8… with matching instr; first out_valid 2 cycles after reset release.
- out_ready=0 with a 1-cycle memory → exactly DEPTH=4 requests issued (0x0–0xC), then imem_req_valid=0 and count=4; raising out_ready resumes issuing at 0x10.
- imem_req_ready=0 for 5 cycles → imem_req_valid stays 1 and imem_req_addr is held at 0x0.
- Memory latency 3 with 3 requests in flight, redirect to 0x100 → the 3 stale responses are discarded; next out_pc=0x100 with the correct instr; no entry from 0x0–0x8 ever appears.
- Redirect to 0x200 in the same cycle as a response and a pop, with FIFO holding 2 entries → FIFO empty next cycle; that response is dropped; the next delivered PC is 0x200.
- Redirect to 0xFFFF_FFFC → next requests 0xFFFF_FFFC then 0x0000_0000 (wrap); with FETCH_PERF_EN, perf_discarded equals the flushed plus dropped count.
